freelist_ctrl: RTL and testbench

FREELIST_CTRL -- requirements
Module: freelist_ctrl

---
 rtl/mips_core_pkg.sv | 26 ++
 rtl/freelist_ctrl_if.sv | 36 +++
 rtl/freelist_ckpt_stack.sv | 68 ++++++
 rtl/freelist_ctrl.sv | 114 +++++++++++
 tb/tb_freelist_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// Shared sizing, types and rename-FSM states for the MIPS core's free-list slice.
package mips_core_pkg;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_CKPT      = 4;

    localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FL_IDX_W = $clog2(FL_DEPTH);

    typedef logic [5:0]        PhysReg;
    typedef logic [1:0]        CkptId;
    typedef logic [FL_IDX_W:0] fl_ptr_t;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } fl_state_e;

    // Distance of a checkpoint id from the oldest live one (0 = oldest).
    function automatic CkptId ckpt_age(input CkptId id, input CkptId oldest);
        return CkptId'(id - oldest);
    endfunction

endpackage

// File: rtl/freelist_ctrl_if.sv
// Rename-stage <-> free-list controller signal bundle.
interface freelist_ctrl_if;
    import mips_core_pkg::*;

    // Handshake: each *_req/*_valid is sampled at the rising edge; alloc_gnt and
    // ckpt_gnt answer combinationally in the same cycle, and a transfer happens
    // at the edge where req and gnt are both high. Release and resolve have no
    // back-pressure: valid alone commits them at the edge.
    logic   ready;
    logic   alloc_req;
    logic   alloc_gnt;
    PhysReg alloc_preg;
    logic   release_valid;
    PhysReg release_preg;
    logic   ckpt_req;
    logic   ckpt_gnt;
    CkptId  ckpt_id;
    logic   resolve_valid;
    CkptId  resolve_id;
    logic   resolve_mispredict;
    logic [5:0] free_count;
    logic   ckpt_full;

    modport master (
        input  ready, alloc_gnt, alloc_preg, ckpt_gnt, ckpt_id, free_count, ckpt_full,
        output alloc_req, release_valid, release_preg, ckpt_req,
               resolve_valid, resolve_id, resolve_mispredict
    );

    modport slave (
        output ready, alloc_gnt, alloc_preg, ckpt_gnt, ckpt_id, free_count, ckpt_full,
        input  alloc_req, release_valid, release_preg, ckpt_req,
               resolve_valid, resolve_id, resolve_mispredict
    );

endinterface

// File: rtl/freelist_ckpt_stack.sv
// Branch checkpoint ring: saved free-list heads, FIFO allocation, and
// squash-from-k recovery on a mispredict.
module freelist_ckpt_stack
    import mips_core_pkg::*;
#(
    parameter int DEPTH = NUM_CKPT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  fl_ptr_t push_head,
    input  logic    resolve_en,
    input  logic    resolve_mispredict,
    input  CkptId   resolve_id,
    output CkptId   push_id,
    output logic    full,
    output logic    restore_hit,
    output fl_ptr_t restore_head
);

    logic [DEPTH-1:0] valid_q;
    fl_ptr_t          head_q [DEPTH];
    CkptId            oldest_q;
    CkptId            next_q;
    logic             commit;

    assign full         = &valid_q;
    assign push_id      = next_q;
    assign restore_hit  = resolve_en & resolve_mispredict & valid_q[resolve_id];
    assign restore_head = head_q[resolve_id];
    assign commit       = resolve_en & ~resolve_mispredict & valid_q[oldest_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            oldest_q <= '0;
            next_q   <= '0;
        end else begin
            // A mispredict on k kills k and everything allocated after it.
            for (int i = 0; i < DEPTH; i++) begin
                if (restore_hit && valid_q[i] &&
                    ckpt_age(CkptId'(i), oldest_q) >= ckpt_age(resolve_id, oldest_q)) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (restore_hit) begin
                next_q <= resolve_id;
            end else if (push) begin
                valid_q[next_q] <= 1'b1;
                next_q          <= CkptId'(next_q + CkptId'(1));
            end
            if (commit) begin
                valid_q[oldest_q] <= 1'b0;
                oldest_q          <= CkptId'(oldest_q + CkptId'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            head_q[next_q] <= push_head;
        end
    end

    a_resolve_oldest: assert property (@(posedge clk) disable iff (!rst_n)
        (resolve_en && !resolve_mispredict) |-> (valid_q[oldest_q] && resolve_id == oldest_q));

endmodule

// File: rtl/freelist_ctrl.sv
// Physical-register free list for rename: circular buffer of free pregs with
// init fill, combinational alloc grant, and checkpoint-based head recovery.
module freelist_ctrl #(
    parameter int NUM_PHYS_REGS = mips_core_pkg::NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS = mips_core_pkg::NUM_ARCH_REGS,
    parameter int NUM_CKPT      = mips_core_pkg::NUM_CKPT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    freelist_ctrl_if.slave          fl,
    output mips_core_pkg::fl_state_e dbg_state
);
    import mips_core_pkg::*;

    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;

    fl_state_e             state_q;
    fl_ptr_t               head_q;
    fl_ptr_t               tail_q;
    logic [FL_IDX_W-1:0]   init_cnt_q;
    logic                  ready_q;
    PhysReg                slot_q [DEPTH];

    logic    running;
    logic    active;
    logic    mispredict;
    logic    release_en;
    logic    ckpt_push;
    fl_ptr_t save_head;
    logic    restore_hit;
    fl_ptr_t restore_head;
    CkptId   push_id;
    logic    ckpt_full;

    assign running    = (state_q == RUN);
    assign active     = (state_q != INIT);
    assign mispredict = fl.resolve_valid & fl.resolve_mispredict;
    assign release_en = active & fl.release_valid;

    assign fl.ready      = ready_q;
    assign fl.free_count = tail_q - head_q;
    assign fl.ckpt_full  = ckpt_full;
    assign fl.ckpt_id    = push_id;
    assign dbg_state     = state_q;

    // An empty list never forwards a same-cycle release; the release lands at tail only.
    assign fl.alloc_gnt  = running & fl.alloc_req & (fl.free_count != '0) & ~mispredict;
    assign fl.alloc_preg = slot_q[head_q[FL_IDX_W-1:0]];
    assign fl.ckpt_gnt   = running & fl.ckpt_req & ~ckpt_full & ~mispredict;
    assign ckpt_push     = fl.ckpt_gnt;

    // The checkpoint records head after this cycle's alloc: that alloc is on the older path.
    assign save_head = head_q + fl_ptr_t'(fl.alloc_gnt);

    freelist_ckpt_stack #(
        .DEPTH (NUM_CKPT)
    ) u_ckpt (
        .clk                (clk),
        .rst_n              (rst_n),
        .push               (ckpt_push),
        .push_head          (save_head),
        .resolve_en         (fl.resolve_valid & active),
        .resolve_mispredict (fl.resolve_mispredict),
        .resolve_id         (fl.resolve_id),
        .push_id            (push_id),
        .full               (ckpt_full),
        .restore_hit        (restore_hit),
        .restore_head       (restore_head)
    );

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            slot_q[tail_q[FL_IDX_W-1:0]] <= PhysReg'(NUM_ARCH_REGS) + PhysReg'(init_cnt_q);
        end else if (release_en) begin
            slot_q[tail_q[FL_IDX_W-1:0]] <= fl.release_preg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            head_q     <= '0;
            tail_q     <= '0;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    tail_q     <= tail_q + fl_ptr_t'(1);
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == FL_IDX_W'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (release_en) begin
                        tail_q <= tail_q + fl_ptr_t'(1);
                    end
                    if (restore_hit) begin
                        head_q  <= restore_head;
                        state_q <= RECOVER;
                    end else begin
                        if (fl.alloc_gnt) begin
                            head_q <= head_q + fl_ptr_t'(1);
                        end
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl: reference free-list/checkpoint model feeding
// an expected-preg queue, checked with immediate assertions.
module tb_freelist_ctrl;
    import mips_core_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    freelist_ctrl_if fl();
    fl_state_e dbg_state;

    freelist_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fl        (fl),
        .dbg_state (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int n_cmp;
    int n_fail;
    logic [5:0] exp_q[$];
    logic [5:0] last_preg;
    logic [1:0] last_ckpt_id;

    logic [5:0] m_slot [32];
    int  m_head, m_tail;
    bit  m_recover;
    bit  m_ck_valid [4];
    int  m_ck_head [4];
    int  m_ck_next, m_ck_oldest, m_ck_live;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 32; i++) m_slot[i] = 6'(32 + i);
        m_head = 0;
        m_tail = 32;
        m_recover = 0;
        for (int i = 0; i < 4; i++) begin
            m_ck_valid[i] = 0;
            m_ck_head[i] = 0;
        end
        m_ck_next = 0;
        m_ck_oldest = 0;
        m_ck_live = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        fl.alloc_req = 0;
        fl.release_valid = 0;
        fl.release_preg = '0;
        fl.ckpt_req = 0;
        fl.resolve_valid = 0;
        fl.resolve_id = '0;
        fl.resolve_mispredict = 0;
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        fl.alloc_req = 1;
        fl.ckpt_req = 1;
        fl.release_valid = 1;
        fl.release_preg = 6'd7;
        #1;
        check({tag, "_init_alloc_gnt"}, fl.alloc_gnt, 0);
        check({tag, "_init_ckpt_gnt"}, fl.ckpt_gnt, 0);
        while (!fl.ready && cyc < 100) begin
            tick();
            cyc++;
        end
        clear_inputs();
        check({tag, "_ready_cycles"}, cyc, 32);
        check({tag, "_init_free"}, fl.free_count, 32);
        check({tag, "_init_state"}, dbg_state, RUN);
        model_init();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        clear_inputs();
        fl.alloc_req = 1;
        fl.ckpt_req = 1;
        tick();
        tick();
        check({tag, "_rst_ready"}, fl.ready, 0);
        check({tag, "_rst_alloc_gnt"}, fl.alloc_gnt, 0);
        check({tag, "_rst_ckpt_gnt"}, fl.ckpt_gnt, 0);
        check({tag, "_rst_free"}, fl.free_count, 0);
        check({tag, "_rst_full"}, fl.ckpt_full, 0);
        check({tag, "_rst_state"}, dbg_state, INIT);
        rst_n = 1;
        wait_ready(tag);
    endtask

    // One RUN/RECOVER cycle: drive, check grants, push/pop scoreboard, update model, check state.
    task automatic do_cycle(input bit alloc, input bit rel, input logic [5:0] rel_preg,
                            input bit ckpt, input bit res_v, input logic [1:0] res_id,
                            input bit res_mp, input string tag);
        bit mp, exp_agnt, exp_cgnt, live_mp;
        int n_kill, id;
        fl.alloc_req = alloc;
        fl.release_valid = rel;
        fl.release_preg = rel_preg;
        fl.ckpt_req = ckpt;
        fl.resolve_valid = res_v;
        fl.resolve_id = res_id;
        fl.resolve_mispredict = res_mp;
        mp = res_v && res_mp;
        exp_agnt = alloc && !m_recover && (m_tail - m_head) != 0 && !mp;
        exp_cgnt = ckpt && !m_recover && m_ck_live != 4 && !mp;
        #1;
        check({tag, "_alloc_gnt"}, fl.alloc_gnt, exp_agnt);
        if (exp_agnt) exp_q.push_back(m_slot[m_head % 32]);
        if (fl.alloc_gnt && exp_q.size() > 0) begin
            last_preg = fl.alloc_preg;
            check({tag, "_alloc_preg"}, fl.alloc_preg, exp_q.pop_front());
        end
        check({tag, "_ckpt_gnt"}, fl.ckpt_gnt, exp_cgnt);
        if (exp_cgnt) begin
            last_ckpt_id = fl.ckpt_id;
            check({tag, "_ckpt_id"}, fl.ckpt_id, m_ck_next);
        end
        live_mp = mp && m_ck_valid[res_id];
        if (exp_cgnt) begin
            m_ck_valid[m_ck_next] = 1;
            m_ck_head[m_ck_next] = m_head + int'(exp_agnt);
            m_ck_next = (m_ck_next + 1) % 4;
            m_ck_live++;
        end
        if (res_v && !res_mp && m_ck_live > 0) begin
            m_ck_valid[m_ck_oldest] = 0;
            m_ck_oldest = (m_ck_oldest + 1) % 4;
            m_ck_live--;
        end
        if (rel) begin
            m_slot[m_tail % 32] = rel_preg;
            m_tail++;
        end
        if (live_mp) begin
            m_head = m_ck_head[res_id];
            n_kill = m_ck_live - ((int'(res_id) - m_ck_oldest + 4) % 4);
            id = int'(res_id);
            for (int k = 0; k < n_kill; k++) begin
                m_ck_valid[id] = 0;
                id = (id + 1) % 4;
            end
            m_ck_live -= n_kill;
            m_ck_next = int'(res_id);
            m_recover = 1;
        end else begin
            if (exp_agnt) m_head++;
            m_recover = 0;
        end
        tick();
        clear_inputs();
        check({tag, "_free_count"}, fl.free_count, m_tail - m_head);
        check({tag, "_ckpt_full"}, fl.ckpt_full, (m_ck_live == 4));
        check({tag, "_state"}, dbg_state, m_recover ? RECOVER : RUN);
    endtask

    task automatic alloc_n(input int n, input string tag);
        for (int i = 0; i < n; i++) do_cycle(1, 0, 6'd0, 0, 0, 2'd0, 0, tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp = 0;
        n_fail = 0;
        last_preg = '0;
        last_ckpt_id = '0;
        clear_inputs();
        model_init();
        @(negedge clk);

        // Reset, INIT fill, first alloc.
        do_reset("s1");
        alloc_n(1, "s1_first");
        check("s1_first_preg", last_preg, 32);

        // Drain the whole list; no bypass of a same-cycle release into an empty list.
        do_reset("s2");
        alloc_n(32, "s2_drain");
        check("s2_last_preg", last_preg, 63);
        check("s2_empty", fl.free_count, 0);
        do_cycle(1, 1, 6'd10, 0, 0, 2'd0, 0, "s2_no_bypass");
        check("s2_after_release", fl.free_count, 1);
        alloc_n(1, "s2_refill");
        check("s2_refill_preg", last_preg, 10);

        // Checkpoint after 3 allocs, 5 more, mispredict restores head.
        do_reset("s3");
        alloc_n(3, "s3_pre");
        do_cycle(0, 0, 6'd0, 1, 0, 2'd0, 0, "s3_ckpt");
        check("s3_ckpt_id", last_ckpt_id, 0);
        alloc_n(5, "s3_spec");
        do_cycle(1, 0, 6'd0, 0, 1, 2'd0, 1, "s3_mispredict");
        check("s3_free_after_mp", fl.free_count, 29);
        do_cycle(1, 0, 6'd0, 1, 0, 2'd0, 0, "s3_recover");
        alloc_n(1, "s3_resume");
        check("s3_resume_preg", last_preg, 35);

        // Checkpoint capacity, wrap, squash of younger ids, dead-id mispredict.
        do_reset("s4");
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 6'd0, 1, 0, 2'd0, 0, "s4_ckpt");
        check("s4_full", fl.ckpt_full, 1);
        do_cycle(0, 0, 6'd0, 1, 0, 2'd0, 0, "s4_fifth");
        do_cycle(0, 0, 6'd0, 0, 1, 2'd0, 0, "s4_resolve0");
        check("s4_not_full", fl.ckpt_full, 0);
        do_cycle(0, 0, 6'd0, 1, 0, 2'd0, 0, "s4_wrap");
        check("s4_wrap_id", last_ckpt_id, 0);
        do_cycle(0, 0, 6'd0, 1, 1, 2'd2, 1, "s4_mp_vs_ckpt");
        do_cycle(0, 0, 6'd0, 1, 0, 2'd0, 0, "s4_recover");
        do_cycle(0, 0, 6'd0, 1, 0, 2'd0, 0, "s4_reuse");
        check("s4_reuse_id", last_ckpt_id, 2);
        do_cycle(0, 0, 6'd0, 0, 1, 2'd3, 1, "s4_dead_mp");
        do_cycle(0, 0, 6'd0, 0, 1, 2'd1, 0, "s4_resolve1");

        // Release during a mispredict; checkpoint taken in an alloc cycle.
        do_reset("s5");
        alloc_n(3, "s5_pre");
        do_cycle(1, 0, 6'd0, 1, 0, 2'd0, 0, "s5_ckpt_alloc");
        alloc_n(2, "s5_spec");
        do_cycle(0, 1, 6'd5, 0, 1, 2'd0, 1, "s5_mp_release");
        check("s5_free_after_mp", fl.free_count, 29);
        do_cycle(0, 0, 6'd0, 0, 0, 2'd0, 0, "s5_recover");
        alloc_n(28, "s5_walk");
        check("s5_walk_last", last_preg, 63);
        alloc_n(1, "s5_tail");
        check("s5_released_preg", last_preg, 5);

        // Asynchronous reset in the middle of RECOVER with two live checkpoints.
        do_reset("s6");
        do_cycle(0, 0, 6'd0, 1, 0, 2'd0, 0, "s6_ckpt");
        do_cycle(1, 0, 6'd0, 1, 0, 2'd0, 0, "s6_ckpt");
        do_cycle(0, 0, 6'd0, 0, 1, 2'd1, 1, "s6_mp");
        fl.alloc_req = 1;
        fl.ckpt_req = 1;
        #2;
        rst_n = 0;
        #1;
        check("s6_async_ready", fl.ready, 0);
        check("s6_async_alloc_gnt", fl.alloc_gnt, 0);
        check("s6_async_ckpt_gnt", fl.ckpt_gnt, 0);
        check("s6_async_free", fl.free_count, 0);
        check("s6_async_full", fl.ckpt_full, 0);
        check("s6_async_state", dbg_state, INIT);
        @(negedge clk);
        do_reset("s6b");
        do_cycle(1, 0, 6'd0, 1, 0, 2'd0, 0, "s6_restart");
        check("s6_restart_preg", last_preg, 32);
        check("s6_restart_ckpt_id", last_ckpt_id, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
